// File: rtl/tmr_vote_pkg.sv
// Shared types and constants for the TMR voting controller.
package tmr_vote_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_A   = 0;
  localparam int unsigned CH_B   = 1;
  localparam int unsigned CH_C   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VOTE    = 2'd2,
    OUT     = 2'd3
  } state_t;

endpackage

// File: rtl/tmr_fault_cnt.sv
// Per-channel consecutive-fault counter with threshold compare and sticky disable.
module tmr_fault_cnt #(
  parameter int unsigned FAULT_THR = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             upd,
  input  logic                             flag,
  output logic                             en,
  output logic                             en_nxt_c,
  output logic [$clog2(FAULT_THR+1)-1:0]   cnt
);

  localparam int unsigned CW = $clog2(FAULT_THR + 1);

  logic [CW-1:0] cnt_d;

  // Next count/enable: clear wins, otherwise update only while still enabled.
  always_comb begin
    cnt_d    = cnt;
    en_nxt_c = en;
    if (clr) begin
      cnt_d    = '0;
      en_nxt_c = 1'b1;
    end else if (upd && en) begin
      if (flag) begin
        cnt_d = cnt + CW'(1);
        if (cnt_d == CW'(FAULT_THR)) en_nxt_c = 1'b0;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Counter and sticky enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      en  <= 1'b1;
    end else begin
      cnt <= cnt_d;
      en  <= en_nxt_c;
    end
  end

endmodule

// File: rtl/tmr_vote_ctrl.sv
// TMR vote sequencer: collect three channel words, 2-of-3 vote, retire faulty channels.
// Optional macro TMR_VOTE_STATS_EN adds per-channel saturating mismatch totals.
module tmr_vote_ctrl
  import tmr_vote_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned FAULT_THR = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_err,
  output logic [NUM_CH-1:0]          ch_mismatch,
  output logic [NUM_CH-1:0]          ch_en,
  input  logic                       clr_fault
`ifdef TMR_VOTE_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]       stat_mis_cnt
`endif
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   captured_q, captured_d, cap_c, ready_d, en_nxt, part, vmis;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   word_q [NUM_CH];
  logic [DATA_W-1:0]   maj, vdata, od_d;
  logic                verr, ov_d, oe_d, all_cap;
  logic [NUM_CH-1:0]   om_d;

  assign cap_c = ch_valid & ch_ready & ch_en;

  // Vote result from the enabled, captured participants.
  always_comb begin
    part  = ch_en & captured_q;
    maj   = (word_q[CH_A] & word_q[CH_B]) | (word_q[CH_A] & word_q[CH_C]) |
            (word_q[CH_B] & word_q[CH_C]);
    vdata = '0;
    verr  = 1'b0;
    vmis  = '0;
    case (part)
      3'b111: begin
        vdata = maj;
        for (int unsigned i = 0; i < NUM_CH; i++) vmis[i] = (word_q[i] != maj);
      end
      3'b011: begin
        vdata = word_q[CH_A];
        if (word_q[CH_A] != word_q[CH_B]) begin verr = 1'b1; vmis = part; end
      end
      3'b101: begin
        vdata = word_q[CH_A];
        if (word_q[CH_A] != word_q[CH_C]) begin verr = 1'b1; vmis = part; end
      end
      3'b110: begin
        vdata = word_q[CH_B];
        if (word_q[CH_B] != word_q[CH_C]) begin verr = 1'b1; vmis = part; end
      end
      3'b001:  begin verr = 1'b1; vdata = word_q[CH_A]; end
      3'b010:  begin verr = 1'b1; vdata = word_q[CH_B]; end
      3'b100:  begin verr = 1'b1; vdata = word_q[CH_C]; end
      default: begin verr = 1'b1; vdata = '0; end
    endcase
    vmis = vmis | (ch_en & ~captured_q);
  end

  // Next-state, capture flags, timer, output payload and registered ready.
  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    timer_d    = timer_q;
    ov_d       = out_valid;
    od_d       = out_data;
    oe_d       = out_err;
    om_d       = ch_mismatch;
    ready_d    = '0;
    all_cap    = (((captured_q | cap_c) & ch_en) == ch_en);
    case (state_q)
      IDLE: begin
        captured_d = captured_q | cap_c;
        if (cap_c != '0) begin
          timer_d = '0;
          state_d = all_cap ? VOTE : COLLECT;
        end
      end
      COLLECT: begin
        captured_d = captured_q | cap_c;
        if (timer_q != '1) timer_d = timer_q + TW'(1);
        if (all_cap || (timer_q == TW'(TIMEOUT - 1))) state_d = VOTE;
      end
      VOTE: begin
        state_d = OUT;
        ov_d    = 1'b1;
        od_d    = vdata;
        oe_d    = verr;
        om_d    = vmis;
      end
      OUT: begin
        if (out_ready) begin
          ov_d       = 1'b0;
          state_d    = IDLE;
          captured_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!en_nxt[i])                                   ready_d[i] = 1'b1;
      else if ((state_d == IDLE) || (state_d == COLLECT)) ready_d[i] = ~captured_d[i];
      else                                              ready_d[i] = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      captured_q  <= '0;
      timer_q     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      ch_mismatch <= '0;
      ch_ready    <= '1;
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      timer_q     <= timer_d;
      out_valid   <= ov_d;
      out_data    <= od_d;
      out_err     <= oe_d;
      ch_mismatch <= om_d;
      ch_ready    <= ready_d;
    end
  end

  // Channel word capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) word_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (cap_c[i]) word_q[i] <= ch_data[i*DATA_W +: DATA_W];
    end
  end

  tmr_fault_cnt #(.FAULT_THR(FAULT_THR)) u_fc_a (
    .clk(clk), .rst(rst), .clr(clr_fault), .upd(state_q == VOTE), .flag(vmis[CH_A]),
    .en(ch_en[CH_A]), .en_nxt_c(en_nxt[CH_A]), .cnt()
  );
  tmr_fault_cnt #(.FAULT_THR(FAULT_THR)) u_fc_b (
    .clk(clk), .rst(rst), .clr(clr_fault), .upd(state_q == VOTE), .flag(vmis[CH_B]),
    .en(ch_en[CH_B]), .en_nxt_c(en_nxt[CH_B]), .cnt()
  );
  tmr_fault_cnt #(.FAULT_THR(FAULT_THR)) u_fc_c (
    .clk(clk), .rst(rst), .clr(clr_fault), .upd(state_q == VOTE), .flag(vmis[CH_C]),
    .en(ch_en[CH_C]), .en_nxt_c(en_nxt[CH_C]), .cnt()
  );

`ifdef TMR_VOTE_STATS_EN
  // Saturating per-channel mismatch totals; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_mis_cnt <= '0;
    end else if (state_q == VOTE) begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (vmis[i] && (stat_mis_cnt[i*16 +: 16] != 16'hFFFF))
          stat_mis_cnt[i*16 +: 16] <= stat_mis_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Directed self-checking bench for tmr_vote_ctrl (default parameters).
module tb_tmr_vote_ctrl;
  import tmr_vote_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [2:0]            ch_valid;
  logic [3*DATA_W-1:0]   ch_data;
  logic [2:0]            ch_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_err;
  logic [2:0]            ch_mismatch;
  logic [2:0]            ch_en;
  logic                  clr_fault;
`ifdef TMR_VOTE_STATS_EN
  logic [47:0]           stat_mis_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  tmr_vote_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .FAULT_THR(3)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .ch_mismatch(ch_mismatch), .ch_en(ch_en), .clr_fault(clr_fault)
`ifdef TMR_VOTE_STATS_EN
    , .stat_mis_cnt(stat_mis_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present words together, optionally pulse clr_fault in the VOTE cycle, check the result.
  task automatic do_vote(input string tag, input logic [2:0] v,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic clr, input logic [2:0] exp_rdy,
                         input logic [7:0] ed, input logic ee, input logic [2:0] em);
    ch_valid = v;
    ch_data  = {c, b, a};
    tick();
    ch_valid = 3'b000;
    ch_data  = '0;
    chk({tag, ".vote_ov"},  32'(out_valid), 32'(1'b0));
    chk({tag, ".vote_rdy"}, 32'(ch_ready),  32'(exp_rdy));
    clr_fault = clr;
    tick();
    clr_fault = 1'b0;
    chk({tag, ".ov"},   32'(out_valid),   32'(1'b1));
    chk({tag, ".data"}, 32'(out_data),    32'(ed));
    chk({tag, ".err"},  32'(out_err),     32'(ee));
    chk({tag, ".mis"},  32'(ch_mismatch), 32'(em));
    tick();
    chk({tag, ".done"}, 32'(out_valid),   32'(1'b0));
  endtask

  initial begin
    int n;
    rst = 1'b1; ch_valid = '0; ch_data = '0; out_ready = 1'b1; clr_fault = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst.ov",  32'(out_valid),   32'(1'b0));
    chk("rst.od",  32'(out_data),    32'h0);
    chk("rst.err", 32'(out_err),     32'(1'b0));
    chk("rst.mis", 32'(ch_mismatch), 32'(3'b000));
    chk("rst.en",  32'(ch_en),       32'(3'b111));
    chk("rst.rdy", 32'(ch_ready),    32'(3'b111));

    // Clean vote
    do_vote("clean", 3'b111, 8'h5A, 8'h5A, 8'h5A, 1'b0, 3'b000, 8'h5A, 1'b0, 3'b000);

    // Single bit flip on b
    do_vote("flip", 3'b111, 8'h5A, 8'h5B, 8'h5A, 1'b0, 3'b000, 8'h5A, 1'b0, 3'b010);
    chk("flip.cnt_b", 32'(dut.u_fc_b.cnt), 32'd1);

    // b keeps failing: second and third consecutive fault
    do_vote("b2", 3'b111, 8'h77, 8'h76, 8'h77, 1'b0, 3'b000, 8'h77, 1'b0, 3'b010);
    chk("b2.en", 32'(ch_en), 32'(3'b111));
    do_vote("b3", 3'b111, 8'h3C, 8'h3D, 8'h3C, 1'b0, 3'b000, 8'h3C, 1'b0, 3'b010);
    chk("b3.en", 32'(ch_en), 32'(3'b101));

    // Degraded 2-of-2: b drained (ready in VOTE), agreement then disagreement
    do_vote("deg_ok",  3'b111, 8'h11, 8'hFF, 8'h11, 1'b0, 3'b010, 8'h11, 1'b0, 3'b000);
    do_vote("deg_bad", 3'b111, 8'h11, 8'hFF, 8'h22, 1'b0, 3'b010, 8'h11, 1'b1, 3'b101);
    chk("deg_bad.cnt_a", 32'(dut.u_fc_a.cnt), 32'd1);

    // clr_fault during VOTE: result still produced, clear beats counter update
    do_vote("clr", 3'b111, 8'h44, 8'h00, 8'h45, 1'b1, 3'b010, 8'h44, 1'b1, 3'b101);
    chk("clr.en",    32'(ch_en),            32'(3'b111));
    chk("clr.cnt_a", 32'(dut.u_fc_a.cnt),   32'd0);
    chk("clr.cnt_b", 32'(dut.u_fc_b.cnt),   32'd0);
    chk("clr.cnt_c", 32'(dut.u_fc_c.cnt),   32'd0);

    // Timeout: c silent. COLLECT runs timer 0..TIMEOUT-1, then VOTE, then OUT
    ch_valid = 3'b011;
    ch_data  = {8'h00, 8'h33, 8'h33};
    tick();
    ch_valid = 3'b000;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("to.lat",   32'(n),             32'(TIMEOUT + 1));
    chk("to.data",  32'(out_data),      32'h33);
    chk("to.err",   32'(out_err),       32'(1'b0));
    chk("to.mis",   32'(ch_mismatch),   32'(3'b100));
    tick();
    chk("to.cnt_c", 32'(dut.u_fc_c.cnt), 32'd1);

    // Backpressure: hold out_ready low, outputs stable, new words not accepted
    out_ready = 1'b0;
    ch_valid  = 3'b111;
    ch_data   = {8'hA4, 8'hA5, 8'hA5};
    tick();
    ch_data   = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.ov",   32'(out_valid),   32'(1'b1));
      chk("bp.data", 32'(out_data),    32'hA5);
      chk("bp.mis",  32'(ch_mismatch), 32'(3'b100));
      chk("bp.rdy",  32'(ch_ready),    32'(3'b000));
    end
    chk("bp.cnt_c", 32'(dut.u_fc_c.cnt), 32'd2);

    // Reset mid-OUT
    rst = 1'b1;
    ch_valid = 3'b000;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mrst.ov",    32'(out_valid),        32'(1'b0));
    chk("mrst.en",    32'(ch_en),            32'(3'b111));
    chk("mrst.rdy",   32'(ch_ready),         32'(3'b111));
    chk("mrst.state", 32'(dut.state_q),      32'(IDLE));
    chk("mrst.cnt_c", 32'(dut.u_fc_c.cnt),   32'd0);

    // Post-reset vote still works
    do_vote("post", 3'b111, 8'h0F, 8'h0F, 8'h0F, 1'b0, 3'b000, 8'h0F, 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
